hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding logic in ID and covers every hazard that forwarding cannot resolve: load-use, branch-in-ID operand hazards and a busy multi-cycle multiply/divide unit. It drives the PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush. It also owns the mul/div latency counter and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl_if.sv | 51 +++++
 rtl/hazard_stall_ctrl.sv | 93 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for hazard_stall_ctrl: ID/EX/MEM hazard inputs and
// the stall, flush and mul/div sequencing outputs.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_Reg_Rs;
  logic [4:0]       IF_ID_Reg_Rt;
  logic             ID_Uses_Rt;
  logic             ID_Branch;
  logic             ID_Branch_Taken;
  logic             ID_Jump;
  logic             ID_MulDiv_Start;
  logic             ID_MulDiv_Op;
  logic             ID_Is_MFHILO;
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_Reg_Rt;
  logic [4:0]       ID_EX_Reg_Rd;
  logic             EX_MEM_MemRead;
  logic [4:0]       EX_MEM_Reg_Rd;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Bubble;
  logic             IF_ID_Flush;
  logic             MD_Start;
  logic             MD_Busy;
  logic             MD_Done;
  logic [1:0]       State;
  logic [CNT_W-1:0] Stall_Count;

  // No valid/ready pair here: the pipeline advances in a cycle exactly when
  // PC_Write/IF_ID_Write are high; a stall holds PC and IF_ID and injects a
  // bubble into ID_EX in that same cycle, so stall and flush never overlap.
  modport master (
    output IF_ID_Reg_Rs, IF_ID_Reg_Rt, ID_Uses_Rt, ID_Branch, ID_Branch_Taken,
           ID_Jump, ID_MulDiv_Start, ID_MulDiv_Op, ID_Is_MFHILO,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Reg_Rt, ID_EX_Reg_Rd,
           EX_MEM_MemRead, EX_MEM_Reg_Rd,
    input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Start,
           MD_Busy, MD_Done, State, Stall_Count
  );

  modport slave (
    input  IF_ID_Reg_Rs, IF_ID_Reg_Rt, ID_Uses_Rt, ID_Branch, ID_Branch_Taken,
           ID_Jump, ID_MulDiv_Start, ID_MulDiv_Op, ID_Is_MFHILO,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Reg_Rt, ID_EX_Reg_Rd,
           EX_MEM_MemRead, EX_MEM_Reg_Rd,
    output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Start,
           MD_Busy, MD_Done, State, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use, branch-in-ID
// operand and mul/div-busy stalls, plus the HI/LO latency counter.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_ctrl_if.slave   bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HOLD    = 2'b01,
    MD_WAIT = 2'b10
  } state_t;

  state_t           state;
  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] stall_count;

  logic ex_rt_hit, ex_rd_hit, mem_rd_hit;
  logic load_use, br_haz, md_haz, stall;
  logic md_busy, md_start;

  // Writes to $0 are never real producers, so r == 0 never matches.
  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign ex_rt_hit  = src_match(bus.ID_EX_Reg_Rt, bus.IF_ID_Reg_Rs,
                                bus.IF_ID_Reg_Rt, bus.ID_Uses_Rt);
  assign ex_rd_hit  = src_match(bus.ID_EX_Reg_Rd, bus.IF_ID_Reg_Rs,
                                bus.IF_ID_Reg_Rt, bus.ID_Uses_Rt);
  assign mem_rd_hit = src_match(bus.EX_MEM_Reg_Rd, bus.IF_ID_Reg_Rs,
                                bus.IF_ID_Reg_Rt, bus.ID_Uses_Rt);

  assign md_busy  = (md_cnt != '0);
  assign load_use = bus.ID_EX_MemRead && ex_rt_hit;
  // Branches compare in ID, so an EX result or a MEM-stage load is too late.
  assign br_haz   = bus.ID_Branch &&
                    ((bus.ID_EX_RegWrite && ex_rd_hit) ||
                     (bus.EX_MEM_MemRead && mem_rd_hit));
  assign md_haz   = md_busy && (bus.ID_MulDiv_Start || bus.ID_Is_MFHILO);
  assign stall    = load_use || br_haz || md_haz;
  assign md_start = bus.ID_MulDiv_Start && !stall;

  assign bus.PC_Write     = !stall;
  assign bus.IF_ID_Write  = !stall;
  assign bus.ID_EX_Bubble = stall;
  assign bus.IF_ID_Flush  = !stall && (bus.ID_Jump ||
                                       (bus.ID_Branch && bus.ID_Branch_Taken));
  assign bus.MD_Start     = md_start;
  assign bus.MD_Busy      = md_busy;
  assign bus.MD_Done      = (md_cnt == MD_W'(1));
  assign bus.State        = state;
  assign bus.Stall_Count  = stall_count;

  // Counter holds remaining busy cycles; LAT..1 gives exactly LAT busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= bus.ID_MulDiv_Op ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
    end else if (md_busy) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else if (md_haz) begin
      state <= MD_WAIT;
    end else if (load_use || br_haz) begin
      state <= HOLD;
    end else begin
      state <= RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MUL_LAT=4, DIV_LAT=32, CNT_W=4 so
// saturation is reachable quickly).
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(32),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    bus.IF_ID_Reg_Rs    = 5'd0;
    bus.IF_ID_Reg_Rt    = 5'd0;
    bus.ID_Uses_Rt      = 1'b0;
    bus.ID_Branch       = 1'b0;
    bus.ID_Branch_Taken = 1'b0;
    bus.ID_Jump         = 1'b0;
    bus.ID_MulDiv_Start = 1'b0;
    bus.ID_MulDiv_Op    = 1'b0;
    bus.ID_Is_MFHILO    = 1'b0;
    bus.ID_EX_MemRead   = 1'b0;
    bus.ID_EX_RegWrite  = 1'b0;
    bus.ID_EX_Reg_Rt    = 5'd0;
    bus.ID_EX_Reg_Rd    = 5'd0;
    bus.EX_MEM_MemRead  = 1'b0;
    bus.EX_MEM_Reg_Rd   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // scoreboard checks
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                         input logic [CNT_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic ctl(input string tag, input logic stall_e, input logic flush_e,
                     input logic mds_e);
    chk1({tag, ".pc_write"}, bus.PC_Write, !stall_e);
    chk1({tag, ".if_id_write"}, bus.IF_ID_Write, !stall_e);
    chk1({tag, ".bubble"}, bus.ID_EX_Bubble, stall_e);
    chk1({tag, ".flush"}, bus.IF_ID_Flush, flush_e);
    chk1({tag, ".md_start"}, bus.MD_Start, mds_e);
  endtask

  task automatic regs(input string tag, input logic [1:0] st_e,
                      input logic [CNT_W-1:0] cnt_e);
    chk2({tag, ".state"}, bus.State, st_e);
    chk_cnt({tag, ".stall_count"}, bus.Stall_Count, cnt_e);
  endtask

  task automatic md(input string tag, input logic busy_e, input logic done_e);
    chk1({tag, ".md_busy"}, bus.MD_Busy, busy_e);
    chk1({tag, ".md_done"}, bus.MD_Done, done_e);
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    n_total = 0;
    n_pass  = 0;
    idle();
    reset = 1'b1;
    #3;
    // reset state with idle inputs
    ctl("rst", 1'b0, 1'b0, 1'b0);
    md("rst", 1'b0, 1'b0);
    regs("rst", 2'b00, 4'd0);
    tick();
    reset = 1'b0;
    #1;

    // load-use: lw $t0 in EX, add reads $t0 in ID
    do_reset();
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1;
    bus.ID_EX_Reg_Rt = 5'd8; bus.ID_EX_Reg_Rd = 5'd8;
    bus.IF_ID_Reg_Rs = 5'd8; bus.IF_ID_Reg_Rt = 5'd9; bus.ID_Uses_Rt = 1'b1;
    settle();
    ctl("lu.c0", 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Reg_Rd = 5'd8;
    bus.IF_ID_Reg_Rs = 5'd8; bus.IF_ID_Reg_Rt = 5'd9; bus.ID_Uses_Rt = 1'b1;
    settle();
    ctl("lu.c1", 1'b0, 1'b0, 1'b0);
    regs("lu.c1", 2'b01, 4'd1);
    tick();
    idle();
    settle();
    regs("lu.c2", 2'b00, 4'd1);

    // taken beq reading $t1 with lw $t1 in EX: two stalls, then flush
    do_reset();
    bus.ID_Branch = 1'b1; bus.ID_Branch_Taken = 1'b1;
    bus.IF_ID_Reg_Rs = 5'd9; bus.IF_ID_Reg_Rt = 5'd10; bus.ID_Uses_Rt = 1'b1;
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1;
    bus.ID_EX_Reg_Rt = 5'd9; bus.ID_EX_Reg_Rd = 5'd9;
    settle();
    ctl("bl.c0", 1'b1, 1'b0, 1'b0);
    tick();
    bus.ID_EX_MemRead = 1'b0; bus.ID_EX_RegWrite = 1'b0;
    bus.ID_EX_Reg_Rt = 5'd0; bus.ID_EX_Reg_Rd = 5'd0;
    bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Reg_Rd = 5'd9;
    settle();
    ctl("bl.c1", 1'b1, 1'b0, 1'b0);
    regs("bl.c1", 2'b01, 4'd1);
    tick();
    bus.EX_MEM_MemRead = 1'b0; bus.EX_MEM_Reg_Rd = 5'd0;
    settle();
    ctl("bl.c2", 1'b0, 1'b1, 1'b0);
    regs("bl.c2", 2'b01, 4'd2);
    tick();
    idle();
    settle();
    ctl("bl.c3", 1'b0, 1'b0, 1'b0);
    regs("bl.c3", 2'b00, 4'd2);

    // not-taken beq with an ALU writer of $t1 in EX: one stall
    do_reset();
    bus.ID_Branch = 1'b1;
    bus.IF_ID_Reg_Rs = 5'd9; bus.IF_ID_Reg_Rt = 5'd10; bus.ID_Uses_Rt = 1'b1;
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Reg_Rd = 5'd9;
    settle();
    ctl("ba.c0", 1'b1, 1'b0, 1'b0);
    tick();
    bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Reg_Rd = 5'd0;
    bus.EX_MEM_Reg_Rd = 5'd9;
    settle();
    ctl("ba.c1", 1'b0, 1'b0, 1'b0);
    regs("ba.c1", 2'b01, 4'd1);

    // taken jump with no hazard flushes immediately
    do_reset();
    bus.ID_Jump = 1'b1;
    settle();
    ctl("jmp", 1'b0, 1'b1, 1'b0);

    // $0 destinations never match
    do_reset();
    bus.ID_Branch = 1'b1; bus.ID_Uses_Rt = 1'b1;
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1;
    bus.EX_MEM_MemRead = 1'b1;
    settle();
    ctl("r0", 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    regs("r0", 2'b00, 4'd0);

    // mult then dependent mflo: 4 busy cycles, mflo stalls all 4
    do_reset();
    bus.ID_MulDiv_Start = 1'b1;
    settle();
    ctl("mul.c0", 1'b0, 1'b0, 1'b1);
    md("mul.c0", 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      idle();
      bus.ID_Is_MFHILO = 1'b1;
      if (i == 1) begin
        // simultaneous load-use: MD_WAIT must win
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Reg_Rt = 5'd8; bus.IF_ID_Reg_Rs = 5'd8;
      end
      settle();
      ctl($sformatf("mul.c%0d", i), 1'b1, 1'b0, 1'b0);
      md($sformatf("mul.c%0d", i), 1'b1, (i == 4));
      regs($sformatf("mul.c%0d", i), (i == 1) ? 2'b00 : 2'b10, CNT_W'(i - 1));
      tick();
    end
    idle();
    bus.ID_Is_MFHILO = 1'b1;
    settle();
    ctl("mul.c5", 1'b0, 1'b0, 1'b0);
    md("mul.c5", 1'b0, 1'b0);
    regs("mul.c5", 2'b10, 4'd4);
    tick();
    idle();
    settle();
    regs("mul.c6", 2'b00, 4'd4);

    // div abandoned by reset at busy cycle 10
    do_reset();
    bus.ID_MulDiv_Start = 1'b1; bus.ID_MulDiv_Op = 1'b1;
    settle();
    ctl("div.c0", 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    bus.ID_Is_MFHILO = 1'b1;
    for (int i = 1; i < 10; i++) tick();
    settle();
    md("div.c10", 1'b1, 1'b0);
    regs("div.c10", 2'b10, 4'd9);
    reset = 1'b1;
    #1;
    md("div.rst", 1'b0, 1'b0);
    regs("div.rst", 2'b00, 4'd0);
    ctl("div.rst", 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      md($sformatf("div.post%0d", i), 1'b0, 1'b0);
      tick();
    end

    // 20 consecutive stalls saturate the 4-bit counter at 4'hF
    do_reset();
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Reg_Rt = 5'd8; bus.IF_ID_Reg_Rs = 5'd8;
    for (int k = 1; k <= 20; k++) begin
      tick();
      settle();
      exp_cnt = (k < 15) ? CNT_W'(k) : 4'hF;
      chk_cnt($sformatf("sat.k%0d", k), bus.Stall_Count, exp_cnt);
    end
    idle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
